// File: rtl/rf_wb_sched.sv
// Writeback port scheduler for the integer register file: round-robin arbitration of
// execute-stage writebacks onto the single write port, plus a busy scoreboard that stalls decode.
module rf_wb_sched #(
    parameter int NREQ = 3,
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      wb_valid,
    output logic [NREQ-1:0]      wb_ready,
    input  logic [5*NREQ-1:0]    wb_rdc,
    input  logic [XLEN*NREQ-1:0] wb_data,
    output logic                 rf_w,
    output logic [4:0]           rf_rdc,
    output logic [XLEN-1:0]      rf_rd,
    input  logic                 iss_valid,
    input  logic                 iss_wr,
    input  logic [4:0]           iss_rdc,
    input  logic [4:0]           iss_rs1c,
    input  logic [4:0]           iss_rs2c,
    output logic                 iss_stall,
    output logic [NREG-1:0]      busy,
    output logic                 sb_err
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gidx;
    logic            xfer;
    logic [4:0]      sel_rdc;
    logic [XLEN-1:0] sel_data;
    logic            rf_w_q, rf_w_d;
    logic [4:0]      rf_rdc_q, rf_rdc_d;
    logic [XLEN-1:0] rf_rd_q, rf_rd_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            sb_err_q, sb_err_d;
    logic            h1, h2, hd, iss_set;

    // Scan from the pointer upward; the first valid requester wins.
    always_comb begin
        int idx;
        grant = '0;
        gidx  = '0;
        xfer  = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!xfer && wb_valid[idx]) begin
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
                xfer       = 1'b1;
            end
        end
    end

    assign wb_ready = grant;
    assign sel_rdc  = wb_rdc[int'(gidx)*5 +: 5];
    assign sel_data = wb_data[int'(gidx)*XLEN +: XLEN];

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);
        end
    end

    // Writes to x0 are accepted but never reach the regfile or the scoreboard.
    always_comb begin
        rf_w_d   = xfer && (sel_rdc != 5'd0);
        rf_rdc_d = rf_rdc_q;
        rf_rd_d  = rf_rd_q;
        if (rf_w_d) begin
            rf_rdc_d = sel_rdc;
            rf_rd_d  = sel_data;
        end
    end

    assign h1        = (iss_rs1c != 5'd0) && busy_q[iss_rs1c];
    assign h2        = (iss_rs2c != 5'd0) && busy_q[iss_rs2c];
    assign hd        = iss_wr && (iss_rdc != 5'd0) && busy_q[iss_rdc];
    assign iss_stall = iss_valid && (h1 || h2 || hd);
    assign iss_set   = iss_valid && iss_wr && !iss_stall && (iss_rdc != 5'd0);

    // Clear lands on the regfile commit edge; the WAW stall keeps set and clear disjoint.
    always_comb begin
        busy_d = busy_q;
        if (rf_w_q) begin
            busy_d[rf_rdc_q] = 1'b0;
        end
        if (iss_set) begin
            busy_d[iss_rdc] = 1'b1;
        end
        busy_d[0] = 1'b0;
        sb_err_d  = sb_err_q || (rf_w_d && !busy_q[sel_rdc]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            rf_w_q   <= 1'b0;
            rf_rdc_q <= '0;
            rf_rd_q  <= '0;
            busy_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            rf_w_q   <= rf_w_d;
            rf_rdc_q <= rf_rdc_d;
            rf_rd_q  <= rf_rd_d;
            busy_q   <= busy_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign rf_w   = rf_w_q;
    assign rf_rdc = rf_rdc_q;
    assign rf_rd  = rf_rd_q;
    assign busy   = busy_q;
    assign sb_err = sb_err_q;
endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed bench for rf_wb_sched with a queue of expected regfile writes.
module tb_rf_wb_sched;
    localparam int NREQ = 3;
    localparam int XLEN = 64;
    localparam int NREG = 32;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      wb_valid;
    logic [NREQ-1:0]      wb_ready;
    logic [5*NREQ-1:0]    wb_rdc;
    logic [XLEN*NREQ-1:0] wb_data;
    logic                 rf_w;
    logic [4:0]           rf_rdc;
    logic [XLEN-1:0]      rf_rd;
    logic                 iss_valid, iss_wr;
    logic [4:0]           iss_rdc, iss_rs1c, iss_rs2c;
    logic                 iss_stall;
    logic [NREG-1:0]      busy;
    logic                 sb_err;

    typedef struct packed {
        logic [4:0]      rdc;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  exp_ptr = 0;

    rf_wb_sched #(.NREQ(NREQ), .XLEN(XLEN), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rdc(wb_rdc), .wb_data(wb_data),
        .rf_w(rf_w), .rf_rdc(rf_rdc), .rf_rd(rf_rd),
        .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_rdc(iss_rdc),
        .iss_rs1c(iss_rs1c), .iss_rs2c(iss_rs2c), .iss_stall(iss_stall),
        .busy(busy), .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [4:0] rdc, input logic [XLEN-1:0] data);
        wb_rdc[i*5 +: 5]        = rdc;
        wb_data[i*XLEN +: XLEN] = data;
    endtask

    // Compare the granted requester against the model and record the expected write.
    task automatic expect_grant(input string tag);
        int g;
        wr_t w;
        g = model_grant(wb_valid, exp_ptr);
        chk(tag, 64'(wb_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        if (g >= 0) begin
            w.rdc  = wb_rdc[g*5 +: 5];
            w.data = wb_data[g*XLEN +: XLEN];
            if (w.rdc != 5'd0) exp_q.push_back(w);
            exp_ptr = (g + 1) % NREQ;
        end
    endtask

    task automatic check_out(input string tag);
        wr_t w;
        if (exp_q.size() == 0) begin
            chk({tag, "_rfw_idle"}, 64'(rf_w), 64'd0);
        end else begin
            w = exp_q.pop_front();
            chk({tag, "_rfw"}, 64'(rf_w), 64'd1);
            chk({tag, "_rdc"}, 64'(rf_rdc), 64'(w.rdc));
            chk({tag, "_data"}, rf_rd, w.data);
        end
    endtask

    task automatic issue(input logic [4:0] rdc);
        iss_valid = 1'b1; iss_wr = 1'b1; iss_rdc = rdc; iss_rs1c = 5'd0; iss_rs2c = 5'd0;
        #1;
        chk("issue_nostall", 64'(iss_stall), 64'd0);
        tick();
        iss_valid = 1'b0; iss_wr = 1'b0; iss_rdc = 5'd0;
    endtask

    task automatic wb_one(input string tag, input int i, input logic [4:0] rdc, input logic [XLEN-1:0] data);
        wb_valid = '0;
        wb_valid[i] = 1'b1;
        set_req(i, rdc, data);
        #1;
        expect_grant({tag, "_ready"});
        tick();
        wb_valid = '0;
        check_out(tag);
    endtask

    // Set and clear of the same register in one cycle must never happen.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (!(rf_w && iss_valid && iss_wr && !iss_stall && iss_rdc != 5'd0 && iss_rdc == rf_rdc)) else begin
                errors++;
                $error("FAIL set_clear_same observed=%0d expected=none", rf_rdc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; wb_valid = '0; wb_rdc = '0; wb_data = '0;
        iss_valid = 1'b0; iss_wr = 1'b0; iss_rdc = '0; iss_rs1c = '0; iss_rs2c = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rfw", 64'(rf_w), 64'd0);
        chk("rst_rdc", 64'(rf_rdc), 64'd0);
        chk("rst_rd", rf_rd, 64'd0);
        chk("rst_err", 64'(sb_err), 64'd0);

        // Single writeback to x7 through requester 1.
        issue(5'd7);
        chk("busy7_set", 64'(busy), 64'h80);
        wb_one("wb7", 1, 5'd7, 64'hDEAD_BEEF);
        chk("busy7_still", 64'(busy), 64'h80);
        tick();
        chk("busy7_clr", 64'(busy), 64'd0);
        check_out("wb7_after");

        // x0 writeback from requester 2 is dropped and also returns the pointer to 0.
        wb_one("x0wb", 2, 5'd0, 64'h1234);
        chk("x0_err", 64'(sb_err), 64'd0);
        chk("x0_busy", 64'(busy), 64'd0);
        issue(5'd0);
        chk("x0_issue_busy", 64'(busy), 64'd0);

        // Round-robin with all requesters valid: no bubble on the write port.
        for (int r = 1; r <= 4; r++) issue(5'(r));
        chk("rr_busy", 64'(busy), 64'h1E);
        wb_valid = 3'b111;
        set_req(0, 5'd1, 64'hA001);
        set_req(1, 5'd2, 64'hA002);
        set_req(2, 5'd3, 64'hA003);
        for (int k = 0; k < 4; k++) begin
            #1;
            expect_grant($sformatf("rr%0d_ready", k));
            tick();
            if (k == 0) set_req(0, 5'd4, 64'hA004);
            if (k == 3) wb_valid = '0;
            check_out($sformatf("rr%0d", k));
        end
        tick();
        check_out("rr_tail");
        chk("rr_busy_done", 64'(busy), 64'd0);
        chk("rr_err", 64'(sb_err), 64'd0);

        // Hazard detection against a busy x9.
        issue(5'd9);
        iss_valid = 1'b1; iss_wr = 1'b0; iss_rs1c = 5'd9; iss_rs2c = 5'd0; iss_rdc = 5'd0;
        #1 chk("raw_rs1", 64'(iss_stall), 64'd1);
        iss_rs1c = 5'd0; iss_rs2c = 5'd9;
        #1 chk("raw_rs2", 64'(iss_stall), 64'd1);
        iss_rs2c = 5'd0; iss_wr = 1'b1; iss_rdc = 5'd9;
        #1 chk("waw", 64'(iss_stall), 64'd1);
        iss_wr = 1'b0;
        #1 chk("no_hazard", 64'(iss_stall), 64'd0);
        iss_valid = 1'b0; iss_rs1c = 5'd9;
        #1 chk("invalid_nostall", 64'(iss_stall), 64'd0);
        iss_valid = 1'b1; iss_wr = 1'b1; iss_rdc = 5'd10;
        #1 chk("stall_rs1_wr", 64'(iss_stall), 64'd1);
        tick();
        iss_valid = 1'b0; iss_wr = 1'b0; iss_rs1c = 5'd0; iss_rdc = 5'd0;
        chk("stalled_noset", 64'(busy), 64'h200);
        wb_one("wb9", exp_ptr, 5'd9, 64'h9999);
        tick();
        chk("busy9_clr", 64'(busy), 64'd0);

        // Simultaneous clear of x13 and set of x14.
        issue(5'd13);
        wb_one("wb13", exp_ptr, 5'd13, 64'h1313);
        issue(5'd14);
        chk("set_clr_both", 64'(busy), 64'h4000);
        wb_one("wb14", exp_ptr, 5'd14, 64'h1414);
        tick();
        chk("busy14_clr", 64'(busy), 64'd0);
        chk("pre_err", 64'(sb_err), 64'd0);

        // Writeback to a register that is not busy flags an error but still writes.
        wb_one("err12", exp_ptr, 5'd12, 64'hC0FFEE);
        chk("err_set", 64'(sb_err), 64'd1);
        tick(); tick();
        check_out("err_idle");
        chk("err_sticky", 64'(sb_err), 64'd1);

        // Asynchronous reset while a write is on the port and another transfer is offered.
        issue(5'd5);
        wb_one("pre_rst", exp_ptr, 5'd5, 64'h5555);
        wb_valid = 3'b001;
        set_req(0, 5'd5, 64'h6666);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_rfw", 64'(rf_w), 64'd0);
        chk("arst_err", 64'(sb_err), 64'd0);
        exp_q.delete();
        tick();
        chk("arst_nowrite", 64'(rf_w), 64'd0);
        wb_valid = '0;
        rst = 1'b0;
        exp_ptr = 0;
        tick();
        chk("post_rst_rfw", 64'(rf_w), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Write-port scheduler and hazard scoreboard for the 32x64 integer register file.
- Arbitrates NREQ writeback sources (ALU, LSU, MDU) round-robin onto the single regfile write port (RF_W/rdc/rd).
- Tracks destination registers with writes in flight and stalls decode on RAW/WAW hazards.
- Sits between the execute-stage writeback buses and the register file; decode reads iss_stall.

Parameters:
NREQ, 3, number of writeback requesters (index 0 = ALU, 1 = LSU, 2 = MDU)
XLEN, 64, data width
NREG, 32, architectural registers (address width fixed at 5)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous active-high reset
wb_valid  in  NREQ  requester i has a writeback pending
wb_ready  out  NREQ  one-hot grant, transfer when wb_valid[i]&wb_ready[i]
wb_rdc  in  5*NREQ  dest register, requester i at [5i+4:5i]
wb_data  in  XLEN*NREQ  write data, requester i at [XLEN*i+XLEN-1:XLEN*i]
rf_w  out  1  regfile write enable (to RF_W)
rf_rdc  out  5  regfile write address
rf_rd  out  XLEN  regfile write data
iss_valid  in  1  decode presents an instruction
iss_wr  in  1  the instruction writes iss_rdc
iss_rdc  in  5  its destination
iss_rs1c  in  5  source 1
iss_rs2c  in  5  source 2
iss_stall  out  1  hold decode this cycle
busy  out  NREG  scoreboard, bit r = write to xr in flight
sb_err  out  1  sticky: writeback to a register not marked busy

Behaviour:
- Reset (async, immediate): busy=0, rr pointer=0, rf_w=0, rf_rdc=0, rf_rd=0, sb_err=0. Accepted but unwritten writebacks are discarded.
- Arbitration (combinational):
  - Scan from requester ptr upward, modulo NREQ. The first i with wb_valid[i] gets wb_ready[i]=1.
  - At most one ready bit per cycle. wb_ready=0 when no valid.
  - wb_ready may depend on wb_valid. Requesters must hold valid/rdc/data stable until the handshake.
- Pointer update: on a transfer from requester i, ptr <= (i+1) mod NREQ. With no transfer, ptr holds.
- Output stage (1-cycle latency, registered):
  - A transfer at cycle t drives rf_w=1 with rf_rdc/rf_rd from that requester during cycle t+1. The regfile commits at the end of t+1.
  - A transfer with rdc==0 is accepted and dropped: rf_w stays 0 and the scoreboard is unaffected.
  - With no transfer, rf_w=0. rf_rdc/rf_rd hold their last values.
  - The output stage never back-pressures, so sustained throughput is 1 writeback/cycle.
- Stall (combinational): iss_stall = iss_valid & (h1 | h2 | hd).
  - h1 = rs1c!=0 & busy[rs1c]
  - h2 = rs2c!=0 & busy[rs2c]
  - hd = iss_wr & rdc!=0 & busy[rdc] (WAW)
- Scoreboard update, on posedge:
  - Set: busy[iss_rdc] <= 1 when iss_valid & iss_wr & !iss_stall & iss_rdc!=0.
  - Clear: busy[rf_rdc] <= 0 when rf_w=1, i.e. the same edge the regfile commits.
  - Readers see busy clear in the cycle after commit and read the new value.
- busy[0] is constant 0.
- Set and clear of the same register in one cycle is impossible: the WAW stall blocks it. The bench asserts it never occurs.
- A transfer with rdc!=0 where busy[rdc]==0 sets sb_err=1. sb_err stays set until reset. The write still proceeds.
- Simultaneous events:
  - Set of reg a and clear of reg b (a!=b) in one cycle both take effect.
  - A transfer and rf_w for different regs in consecutive cycles pipeline with no bubble.

Test Plan:
- Reset check: assert rst mid-transfer (wb_valid=3'b001, rdc=5) -> busy=0, rf_w=0 and sb_err=0 immediately, without a clock edge; no write on the next edge.
- Single writeback: issue rdc=7 (busy[7]=1); next cycle wb_valid[1]=1, rdc=7, data=64'hDEAD_BEEF -> wb_ready=3'b010; following cycle rf_w=1, rf_rdc=7, rf_rd=DEADBEEF; busy[7]=0 after that edge.
- Round-robin: all three valid continuously, ptr=0 -> grants 001, 010, 100, 001; rf_w high 4 consecutive cycles with no bubble.
- Hazards: busy[9]=1; issue rs1c=9 -> iss_stall=1; issue rs2c=0 with rdc=9 -> iss_stall=1 (WAW); issue rs1c=0, rs2c=0, iss_wr=0 -> iss_stall=0.
- x0 handling: issue iss_rdc=0 -> busy unchanged; wb_rdc=0 transfer -> wb_ready pulses, rf_w stays 0, sb_err stays 0.
- Error: transfer rdc=12 with busy[12]=0 -> sb_err=1 and write still occurs (rf_w=1, rf_rdc=12); sb_err stays 1 until rst.
